// File: rtl/mod_exp_arbiter.sv
// Two-requester round-robin front end for a shared modular-exponentiation
// engine, with per-job timeout, engine reset pulse and error counter.
module mod_exp_arbiter #(
    parameter int BITS    = 64,
    parameter int TIMEOUT = 20000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_m,
    input  logic [BITS-1:0] req0_e,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_m,
    input  logic [BITS-1:0] req1_e,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [BITS-1:0] rsp_data,
    output logic            rsp_err,
    output logic            exp_in_valid,
    output logic [BITS-1:0] exp_m,
    output logic [BITS-1:0] exp_e,
    input  logic            exp_out_valid,
    input  logic [BITS-1:0] exp_out,
    output logic            exp_rst,
    output logic            busy,
    output logic [7:0]      err_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BUSY    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic [BITS-1:0] m_q, m_d;
    logic [BITS-1:0] e_q, e_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            exp_in_valid_q, exp_in_valid_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [BITS-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      err_count_q, err_count_d;

    logic grant0, grant1;
    logic timeout_hit;
    logic owner_ready;

    // Grant selection: a lone requester wins; on a tie the one not served last.
    always_comb begin
        grant1      = req1_valid & (~req0_valid | ~last_grant_q);
        grant0      = req0_valid & ~grant1;
        req0_ready  = (state_q == IDLE) & grant0;
        req1_ready  = (state_q == IDLE) & grant1;
        timeout_hit = (state_q == BUSY) & ~exp_out_valid &
                      (timer_q == TW'(TIMEOUT - 1));
        owner_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state and registered-output computation for the job FSM.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        m_d            = m_q;
        e_d            = e_q;
        timer_d        = timer_q;
        exp_in_valid_d = 1'b0;
        rsp0_valid_d   = rsp0_valid_q;
        rsp1_valid_d   = rsp1_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        err_count_d    = err_count_q;
        case (state_q)
            IDLE: begin
                if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) begin
                    owner_d        = grant1;
                    m_d            = grant1 ? req1_m : req0_m;
                    e_d            = grant1 ? req1_e : req0_e;
                    exp_in_valid_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (exp_out_valid) begin
                    rsp_data_d   = exp_out;
                    rsp_err_d    = 1'b0;
                    rsp0_valid_d = ~owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = RESPOND;
                end else if (timeout_hit) begin
                    rsp_data_d   = '0;
                    rsp_err_d    = 1'b1;
                    rsp0_valid_d = ~owner_q;
                    rsp1_valid_d = owner_q;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    state_d      = RESPOND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESPOND: begin
                if (owner_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            m_q            <= '0;
            e_q            <= '0;
            timer_q        <= '0;
            exp_in_valid_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            m_q            <= m_d;
            e_q            <= e_d;
            timer_q        <= timer_d;
            exp_in_valid_q <= exp_in_valid_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign exp_in_valid = exp_in_valid_q;
    assign exp_m        = m_q;
    assign exp_e        = e_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign err_count    = err_count_q;
    assign busy         = (state_q != IDLE);
    assign exp_rst      = rst | timeout_hit;

endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Directed bench for mod_exp_arbiter: one instance with a long timeout for
// arbitration/handshake cases, one with TIMEOUT=8 for expiry cases.
module tb_mod_exp_arbiter;

    localparam int W = 16;

    logic clk;
    logic rst;

    logic         a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
    logic [W-1:0] a_req0_m, a_req0_e, a_req1_m, a_req1_e;
    logic         a_rsp0_valid, a_rsp0_ready, a_rsp1_valid, a_rsp1_ready;
    logic [W-1:0] a_rsp_data, a_exp_m, a_exp_e, a_exp_out;
    logic         a_rsp_err, a_exp_in_valid, a_exp_out_valid, a_exp_rst, a_busy;
    logic [7:0]   a_err_count;

    logic         b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [W-1:0] b_req0_m, b_req0_e, b_req1_m, b_req1_e;
    logic         b_rsp0_valid, b_rsp0_ready, b_rsp1_valid, b_rsp1_ready;
    logic [W-1:0] b_rsp_data, b_exp_m, b_exp_e, b_exp_out;
    logic         b_rsp_err, b_exp_in_valid, b_exp_out_valid, b_exp_rst, b_busy;
    logic [7:0]   b_err_count;

    int n_cmp = 0;
    int n_err = 0;

    mod_exp_arbiter #(.BITS(W), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
        .req0_m(a_req0_m), .req0_e(a_req0_e),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
        .req1_m(a_req1_m), .req1_e(a_req1_e),
        .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready),
        .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .exp_in_valid(a_exp_in_valid), .exp_m(a_exp_m), .exp_e(a_exp_e),
        .exp_out_valid(a_exp_out_valid), .exp_out(a_exp_out),
        .exp_rst(a_exp_rst), .busy(a_busy), .err_count(a_err_count)
    );

    mod_exp_arbiter #(.BITS(W), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_m(b_req0_m), .req0_e(b_req0_e),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_m(b_req1_m), .req1_e(b_req1_e),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
        .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .exp_in_valid(b_exp_in_valid), .exp_m(b_exp_m), .exp_e(b_exp_e),
        .exp_out_valid(b_exp_out_valid), .exp_out(b_exp_out),
        .exp_rst(b_exp_rst), .busy(b_busy), .err_count(b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic b_timeout_job;
        b_req0_valid = 1'b1;
        tick;
        b_req0_valid = 1'b0;
        repeat (9) tick;
        b_rsp0_ready = 1'b1;
        tick;
        b_rsp0_ready = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;
        int bad;
        logic g;
        logic [W-1:0] m_exp;

        rst = 1'b1;
        a_req0_valid = 0; a_req1_valid = 0; a_req0_m = 0; a_req0_e = 0;
        a_req1_m = 0; a_req1_e = 0; a_rsp0_ready = 0; a_rsp1_ready = 0;
        a_exp_out_valid = 0; a_exp_out = 0;
        b_req0_valid = 0; b_req1_valid = 0; b_req0_m = 0; b_req0_e = 0;
        b_req1_m = 0; b_req1_e = 0; b_rsp0_ready = 0; b_rsp1_ready = 0;
        b_exp_out_valid = 0; b_exp_out = 0;

        // reset state
        tick; tick;
        chk("rst_busy", a_busy, 0);
        chk("rst_rsp0_valid", a_rsp0_valid, 0);
        chk("rst_rsp1_valid", a_rsp1_valid, 0);
        chk("rst_exp_in_valid", a_exp_in_valid, 0);
        chk("rst_rsp_data", a_rsp_data, 0);
        chk("rst_err_count", a_err_count, 0);
        chk("rst_exp_rst", a_exp_rst, 1);
        rst = 1'b0;
        tick;
        chk("idle_exp_rst", a_exp_rst, 0);

        // single job from req0, engine answers after 40 cycles
        a_req0_m = 5; a_req0_e = 3; a_req0_valid = 1'b1;
        #1;
        chk("j1_req0_ready", a_req0_ready, 1);
        chk("j1_req1_ready", a_req1_ready, 0);
        tick;
        a_req0_valid = 1'b0;
        chk("j1_exp_in_valid", a_exp_in_valid, 1);
        chk("j1_exp_m", a_exp_m, 5);
        chk("j1_exp_e", a_exp_e, 3);
        chk("j1_issue_busy", a_busy, 1);
        tick;
        chk("j1_exp_in_valid_off", a_exp_in_valid, 0);
        repeat (39) tick;
        a_exp_out = 125; a_exp_out_valid = 1'b1;
        tick;
        a_exp_out_valid = 1'b0; a_exp_out = 0;
        chk("j1_rsp0_valid", a_rsp0_valid, 1);
        chk("j1_rsp1_valid", a_rsp1_valid, 0);
        chk("j1_rsp_data", a_rsp_data, 125);
        chk("j1_rsp_err", a_rsp_err, 0);
        chk("j1_exp_m_hold", a_exp_m, 5);
        a_exp_out = 77; a_exp_out_valid = 1'b1;
        tick;
        a_exp_out_valid = 1'b0;
        chk("j1_late_out_ignored", a_rsp_data, 125);
        a_rsp0_ready = 1'b1;
        tick;
        a_rsp0_ready = 1'b0;
        chk("j1_rsp0_drop", a_rsp0_valid, 0);
        chk("j1_idle", a_busy, 0);

        // round-robin from reset, three jobs each
        rst = 1'b1;
        tick;
        rst = 1'b0;
        c0 = 0; c1 = 0;
        for (int j = 0; j < 6; j++) begin
            g = j[0];
            a_req0_valid = (c0 < 3);
            a_req1_valid = (c1 < 3);
            a_req0_m = W'(16'h100 + c0);
            a_req1_m = W'(16'h200 + c1);
            m_exp = g ? W'(16'h200 + c1) : W'(16'h100 + c0);
            #1;
            chk("rr_req0_ready", a_req0_ready, {31'd0, ~g});
            chk("rr_req1_ready", a_req1_ready, {31'd0, g});
            tick;
            a_req0_valid = 1'b0; a_req1_valid = 1'b0;
            if (g) c1++; else c0++;
            chk("rr_exp_m", a_exp_m, m_exp);
            tick;
            a_exp_out = W'(16'h50 + j); a_exp_out_valid = 1'b1;
            tick;
            a_exp_out_valid = 1'b0;
            chk("rr_rsp0_valid", a_rsp0_valid, {31'd0, ~g});
            chk("rr_rsp1_valid", a_rsp1_valid, {31'd0, g});
            chk("rr_rsp_data", a_rsp_data, 32'h50 + j);
            if (g) a_rsp1_ready = 1'b1; else a_rsp0_ready = 1'b1;
            tick;
            a_rsp0_ready = 1'b0; a_rsp1_ready = 1'b0;
            chk("rr_idle", a_busy, 0);
        end

        // req1 response held off for 50 cycles, req0 waiting
        a_req1_m = 16'h0321; a_req1_valid = 1'b1;
        #1;
        chk("hold_req1_ready", a_req1_ready, 1);
        tick;
        a_req1_valid = 1'b0;
        tick;
        a_exp_out = 16'hA5A5; a_exp_out_valid = 1'b1;
        tick;
        a_exp_out_valid = 1'b0;
        a_req0_m = 9; a_req0_valid = 1'b1; a_rsp0_ready = 1'b1;
        bad = 0;
        repeat (50) begin
            tick;
            if (a_rsp_data !== 16'hA5A5 || a_req0_ready !== 1'b0 ||
                a_rsp1_valid !== 1'b1 || a_rsp0_valid !== 1'b0)
                bad++;
        end
        chk("hold_bad_cycles", bad, 0);
        a_rsp0_ready = 1'b0;
        a_rsp1_ready = 1'b1;
        tick;
        a_rsp1_ready = 1'b0;
        chk("hold_release_idle", a_busy, 0);
        chk("hold_release_rsp1", a_rsp1_valid, 0);
        chk("hold_req0_ready", a_req0_ready, 1);
        a_req0_valid = 1'b0;
        tick;
        chk("withdraw_no_job", a_busy, 0);
        chk("withdraw_no_issue", a_exp_in_valid, 0);

        // reset while busy
        a_req0_m = 33; a_req0_valid = 1'b1;
        tick;
        a_req0_valid = 1'b0;
        tick; tick;
        chk("mid_busy", a_busy, 1);
        rst = 1'b1;
        tick;
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_rsp0", a_rsp0_valid, 0);
        chk("mid_rst_issue", a_exp_in_valid, 0);
        chk("mid_rst_exp_m", a_exp_m, 0);
        chk("mid_rst_exp_rst", a_exp_rst, 1);
        rst = 1'b0;
        a_exp_out = 1; a_exp_out_valid = 1'b1;
        tick;
        a_exp_out_valid = 1'b0;
        chk("post_rst_rsp0", a_rsp0_valid, 0);
        chk("post_rst_busy", a_busy, 0);
        chk("post_rst_exp_rst", a_exp_rst, 0);

        // silent engine, TIMEOUT=8
        b_req0_m = 7; b_req0_e = 2; b_req0_valid = 1'b1;
        tick;
        b_req0_valid = 1'b0;
        tick;
        repeat (6) tick;
        chk("to_busy7_exp_rst", b_exp_rst, 0);
        tick;
        chk("to_busy8_exp_rst", b_exp_rst, 1);
        chk("to_busy8_busy", b_busy, 1);
        tick;
        chk("to_rsp0_valid", b_rsp0_valid, 1);
        chk("to_rsp_err", b_rsp_err, 1);
        chk("to_rsp_data", b_rsp_data, 0);
        chk("to_err_count", b_err_count, 1);
        chk("to_exp_rst_off", b_exp_rst, 0);
        b_rsp0_ready = 1'b1;
        tick;
        b_rsp0_ready = 1'b0;

        // result arriving on the expiry cycle wins
        b_req1_m = 8; b_req1_valid = 1'b1;
        tick;
        b_req1_valid = 1'b0;
        tick;
        repeat (7) tick;
        b_exp_out = 16'hBEEF; b_exp_out_valid = 1'b1;
        #1;
        chk("tie_exp_rst", b_exp_rst, 0);
        tick;
        b_exp_out_valid = 1'b0;
        chk("tie_rsp1_valid", b_rsp1_valid, 1);
        chk("tie_rsp_err", b_rsp_err, 0);
        chk("tie_rsp_data", b_rsp_data, 16'hBEEF);
        chk("tie_err_count", b_err_count, 1);
        b_rsp1_ready = 1'b1;
        tick;
        b_rsp1_ready = 1'b0;

        // error counter saturation
        repeat (254) b_timeout_job;
        chk("sat_err_count_255", b_err_count, 255);
        b_timeout_job;
        chk("sat_err_count_hold", b_err_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_exp_arbiter.md
MOD_EXP_ARBITER -- requirements
Module: mod_exp_arbiter

Interface
REQ-001 Parameter: BITS, 64, operand/result width.
REQ-002 Parameter: TIMEOUT, 20000, max cycles waited for engine result (>=2).
REQ-003 Port: clk  in  1  system clock, all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: req0_valid in 1, req0_ready out 1, req0_m in BITS, req0_e in BITS; requester 0 job (message, exponent).
REQ-006 Ports: req1_valid, req1_ready, req1_m, req1_e; same widths and meaning, requester 1.
REQ-007 Ports: rsp0_valid out 1, rsp0_ready in 1; rsp1_valid out 1, rsp1_ready in 1; per-requester response handshake.
REQ-008 Ports: rsp_data out BITS result; rsp_err out 1 timeout flag; shared, valid only with rspN_valid.
REQ-009 Ports: exp_in_valid out 1, exp_m out BITS, exp_e out BITS, exp_out_valid in 1, exp_out in BITS, exp_rst out 1; mod_exp engine side.
REQ-010 Ports: busy out 1 state!=IDLE; err_count out 8 timeout count.

Function
REQ-011 FSM shall have states IDLE, ISSUE, BUSY, RESPOND.
REQ-012 In IDLE the block shall assert reqN_ready combinationally for the granted requester only; other ready, and all ready outside IDLE, shall be 0.
REQ-013 Grant: only one valid -> that one; both valid -> the requester not in last_grant (round-robin).
REQ-014 On accept (valid&ready) the block shall latch m, e, owner and go to ISSUE next cycle.
REQ-015 exp_m/exp_e shall be driven from latched registers and stay stable from ISSUE until return to IDLE.
REQ-016 ISSUE: exp_in_valid=1 for exactly one cycle; timer cleared; next state BUSY.
REQ-017 BUSY: timer increments each cycle; on exp_out_valid latch exp_out into rsp_data, rsp_err=0, go RESPOND.
REQ-018 BUSY with timer==TIMEOUT-1 and no exp_out_valid: rsp_data=0, rsp_err=1, exp_rst one-cycle pulse, err_count+1 saturating at 255, go RESPOND.
REQ-019 exp_out_valid in the same cycle as timeout expiry shall win (normal result, no error).
REQ-020 RESPOND: rspN_valid=1 for owner only, data/err held; on rspN_ready go IDLE next cycle and set last_grant=owner.
REQ-021 exp_out_valid outside BUSY shall be ignored.
REQ-022 Latency: accept at cycle T -> exp_in_valid at T+1; exp_out_valid at cycle U -> rspN_valid at U+1.
REQ-023 reqN_valid deassertion before acceptance shall be legal; no job started.
REQ-024 rspN_ready outside RESPOND or for non-owner shall be ignored.

Reset
REQ-025 Under rst: state IDLE, last_grant=1 (req0 wins first tie), all outputs 0 except exp_rst.
REQ-026 exp_rst shall equal rst OR timeout pulse.
REQ-027 Reset mid-transaction shall drop the job with no response; err_count cleared to 0.

Verification
REQ-028 req0 only, m=5,e=3; engine returns 125 after 40 cycles -> exp_in_valid one cycle after accept, rsp0_valid, rsp_data=125, rsp_err=0.
REQ-029 req0 and req1 valid same cycle from reset, 3 jobs each -> grants 0,1,0,1,0,1.
REQ-030 TIMEOUT=8, engine silent -> exp_rst pulse at 8th BUSY cycle, rsp_err=1, rsp_data=0, err_count=1.
REQ-031 exp_out_valid coincident with timeout -> rsp_err=0, data=exp_out, err_count unchanged.
REQ-032 Hold rsp1_ready=0 for 50 cycles in RESPOND -> data stable, req0_ready=0 throughout; release -> IDLE next cycle.
REQ-033 rst asserted in BUSY -> next cycle IDLE, all outputs 0, no rspN_valid.
